// File: rtl/mcpu_intc_pkg.sv
// mcpu_intc_pkg
// Shared definitions for the interrupt controller:
//   - MMIO word offsets of the four controller registers
//   - STATUS register bit positions
//   - controller state encoding
//   - upper bound on the number of sources (the active id is 4 bits wide)
//   - byte_mask(): expands 4 byte enables into a 32-bit bit mask
package mcpu_intc_pkg;

    localparam int NSRC_MAX = 16;
    localparam int ID_W     = 4;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_RAW     = 2'd3;

    localparam int INSVC_BIT = 31;
    localparam int ID_LSB    = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        SERVICE = 2'd2
    } intc_state_e;

    function automatic logic [31:0] byte_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/mcpu_intc_prio_enc.sv
// mcpu_intc_prio_enc
// Lowest-index-wins priority encoder.
// Ports:
//   req   in  W  request vector (bit 0 is the highest priority)
//   valid out 1  at least one request present
//   id    out 4  index of the winning request (0 when none)
module mcpu_intc_prio_enc #(
    parameter int W = 8
) (
    input  logic [W-1:0] req,
    output logic         valid,
    output logic [3:0]   id
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        valid = |req;
        id    = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = 4'(i);
            end
        end
    end

endmodule

// File: rtl/mcpu_soc_intc.sv
// mcpu_soc_intc
// Interrupt controller for the core's int_pending/int_type/int_clear port.
// Latches peripheral interrupt edges, masks them with ENABLE, arbitrates by
// fixed priority (index 0 highest) and offers one interrupt at a time. The
// offered interrupt is held in service until software writes STATUS (EOI).
//
// Optional build macro: MCPU_INTC_LEVEL_EN -- when defined, sources whose
// LEVEL_MASK bit is set are level-sensitive (pending follows irq_src).
//
// Ports:
//   clkrst_core_clk in  1     core clock, rising edge
//   clkrst_core_rst in  1     synchronous active-high reset
//   irq_src         in  NSRC  raw interrupt lines (already synchronous)
//   mmio_addr       in  2     register word select
//   mmio_wren       in  4     byte write enables
//   mmio_re         in  1     read strobe
//   mmio_data_in    in  32    write data
//   mmio_data_out   out 32    registered read data, held between reads
//   int_pending     out 1     interrupt offered to the core
//   int_type        out 4     id of the offered source
//   int_clear       in  1     core accepted the offered interrupt
module mcpu_soc_intc
    import mcpu_intc_pkg::*;
#(
    parameter int                    NSRC       = 8,
    parameter logic [NSRC_MAX-1:0]   LEVEL_MASK = '0
) (
    input  logic             clkrst_core_clk,
    input  logic             clkrst_core_rst,
    input  logic [NSRC-1:0]  irq_src,
    input  logic [1:0]       mmio_addr,
    input  logic [3:0]       mmio_wren,
    input  logic             mmio_re,
    input  logic [31:0]      mmio_data_in,
    output logic [31:0]      mmio_data_out,
    output logic             int_pending,
    output logic [ID_W-1:0]  int_type,
    input  logic             int_clear
);

    logic [NSRC-1:0] prev_reg;
    logic [NSRC-1:0] pending_reg;
    logic [NSRC-1:0] pending_next;
    logic [NSRC-1:0] enable_reg;
    logic [NSRC-1:0] enable_next;
    logic [31:0]     data_out_reg;
    logic [31:0]     rdata;

    intc_state_e     state_reg;
    intc_state_e     state_next;
    logic [ID_W-1:0] active_id_reg;
    logic [ID_W-1:0] active_id_next;

    logic [31:0]     wmask;
    logic [31:0]     wdata_m;
    logic            wr_any;
    logic            eoi;
    logic            accept;
    logic            act_cand;
    logic [NSRC-1:0] cand;
    logic [NSRC-1:0] lsb_one;
    logic [NSRC-1:0] act_onehot;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] acc_clr;
    logic [NSRC-1:0] edges;
    logic [NSRC-1:0] edge_pending;
    logic            enc_valid;
    logic [ID_W-1:0] enc_id;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    assign wmask   = byte_mask(mmio_wren);
    assign wdata_m = mmio_data_in & wmask;
    assign wr_any  = |mmio_wren;

    // Only bits [NSRC-1:0] of the write data matter; the rest is discarded.
    logic unused_bits;
    assign unused_bits = ^wdata_m;

    assign w1c = (mmio_addr == REG_PENDING) ? wdata_m[NSRC-1:0] : '0;
    assign eoi = wr_any && (mmio_addr == REG_STATUS) && (state_reg == SERVICE);

    assign enable_next = (mmio_addr == REG_ENABLE)
                       ? ((enable_reg & ~wmask[NSRC-1:0]) | wdata_m[NSRC-1:0])
                       : enable_reg;

    // ------------------------------------------------------------------
    // Candidates and arbitration
    // ------------------------------------------------------------------
    assign cand = pending_reg & enable_reg;

    always_comb begin
        lsb_one    = '0;
        lsb_one[0] = 1'b1;
    end

    // One-hot of the frozen active id; a shift keeps the index in range
    // for any NSRC without a narrowing part-select.
    assign act_onehot = lsb_one << active_id_reg;
    assign act_cand   = |(cand & act_onehot);

    mcpu_intc_prio_enc #(
        .W (NSRC)
    ) u_prio_enc (
        .req   (cand),
        .valid (enc_valid),
        .id    (enc_id)
    );

    assign accept  = (state_reg == OFFER) && act_cand && int_clear;
    assign acc_clr = accept ? act_onehot : '0;

    // ------------------------------------------------------------------
    // Pending update: clears first, then a fresh edge re-sets the bit.
    // ------------------------------------------------------------------
    assign edges        = irq_src & ~prev_reg;
    assign edge_pending = (pending_reg & ~w1c & ~acc_clr) | edges;

`ifdef MCPU_INTC_LEVEL_EN
    localparam logic [NSRC-1:0] LEVEL_BITS = LEVEL_MASK[NSRC-1:0];
    assign pending_next = (edge_pending & ~LEVEL_BITS) | (irq_src & LEVEL_BITS);
`else
    localparam logic [NSRC_MAX-1:0] UNUSED_LEVEL_MASK = LEVEL_MASK;
    assign pending_next = edge_pending;
`endif

    // ------------------------------------------------------------------
    // Read mux (sampled into data_out_reg on mmio_re, so reads see
    // pre-write register values)
    // ------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        case (mmio_addr)
            REG_PENDING: rdata[NSRC-1:0] = pending_reg;
            REG_ENABLE:  rdata[NSRC-1:0] = enable_reg;
            REG_STATUS: begin
                rdata[INSVC_BIT]         = (state_reg == SERVICE);
                rdata[ID_LSB +: ID_W]    = active_id_reg;
            end
            default:     rdata[NSRC-1:0] = irq_src;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            // Track the line during reset so a level held across reset
            // does not look like an edge afterwards.
            prev_reg     <= irq_src;
            pending_reg  <= '0;
            enable_reg   <= '0;
            data_out_reg <= '0;
        end else begin
            prev_reg    <= irq_src;
            pending_reg <= pending_next;
            enable_reg  <= enable_next;
            if (mmio_re) begin
                data_out_reg <= rdata;
            end
        end
    end

    assign mmio_data_out = data_out_reg;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
            state_reg     <= IDLE;
            active_id_reg <= '0;
        end else begin
            state_reg     <= state_next;
            active_id_reg <= active_id_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        active_id_next = active_id_reg;
        case (state_reg)
            IDLE: begin
                if (enc_valid) begin
                    state_next     = OFFER;
                    active_id_next = enc_id;
                end
            end
            OFFER: begin
                // The winner stays frozen; only its own disappearance or
                // the core's accept moves us on.
                if (!act_cand) begin
                    state_next = IDLE;
                end else if (int_clear) begin
                    state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. The offer is withdrawn in the same cycle its
    // candidate vanishes so the core never sees a stale request.
    // ------------------------------------------------------------------
    always_comb begin
        int_pending = (state_reg == OFFER) && act_cand;
        int_type    = active_id_reg;
    end

endmodule

// File: tb/tb_mcpu_soc_intc.sv
// tb_mcpu_soc_intc
// Directed scenarios followed by random traffic, each cycle compared with a
// behavioural model of the controller kept in this bench.
module tb_mcpu_soc_intc;

    localparam int NSRC = 8;
`ifdef MCPU_INTC_LEVEL_EN
    localparam logic [15:0] TB_LVL = 16'h0001;
`else
    localparam logic [15:0] TB_LVL = 16'h0000;
`endif

    logic            clk;
    logic            srst;
    logic [NSRC-1:0] src;
    logic [1:0]      addr;
    logic [3:0]      wren;
    logic            re;
    logic [31:0]     din;
    logic [31:0]     dout;
    logic            ipend;
    logic [3:0]      itype;
    logic            clr;

    int total_checks;
    int passed_checks;
    int failed_checks;

    // Behavioural model state
    logic [NSRC-1:0] m_pend;
    logic [NSRC-1:0] m_en;
    logic [NSRC-1:0] m_prev;
    bit              m_offer;
    bit              m_svc;
    int              m_act;
    logic [31:0]     m_dout;

    mcpu_soc_intc #(
        .NSRC       (NSRC),
        .LEVEL_MASK (TB_LVL)
    ) dut (
        .clkrst_core_clk (clk),
        .clkrst_core_rst (srst),
        .irq_src         (src),
        .mmio_addr       (addr),
        .mmio_wren       (wren),
        .mmio_re         (re),
        .mmio_data_in    (din),
        .mmio_data_out   (dout),
        .int_pending     (ipend),
        .int_type        (itype),
        .int_clear       (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks++;
        else begin
            failed_checks++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [NSRC-1:0] v);
        for (int i = 0; i < NSRC; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Advance the model by one clock using the inputs currently driven,
    // clock the DUT, then compare its outputs with the model.
    task automatic step();
        logic [31:0]     wm;
        logic [31:0]     w32;
        logic [NSRC-1:0] w1c;
        logic [NSRC-1:0] cand;
        logic [NSRC-1:0] np;
        logic [31:0]     rv;
        bit              eoi_wr;
        int              acc_id;
        if (srst) begin
            m_pend  = '0;
            m_en    = '0;
            m_offer = 0;
            m_svc   = 0;
            m_act   = 0;
            m_dout  = '0;
            m_prev  = src;
        end else begin
            wm = '0;
            for (int b = 0; b < 4; b++) begin
                if (wren[b]) wm = wm | (32'hFF << (8 * b));
            end
            w32    = din & wm;
            w1c    = (addr == 2'd0) ? w32[NSRC-1:0] : '0;
            eoi_wr = (addr == 2'd2) && (wren != 4'd0);
            cand   = m_pend & m_en;
            acc_id = -1;
            if (re) begin
                rv = '0;
                case (addr)
                    2'd0: rv[NSRC-1:0] = m_pend;
                    2'd1: rv[NSRC-1:0] = m_en;
                    2'd2: rv = {m_svc, 27'd0, 4'(m_act)};
                    default: rv[NSRC-1:0] = src;
                endcase
                m_dout = rv;
            end
            if (!m_offer && !m_svc) begin
                if (cand != '0) begin
                    m_offer = 1;
                    m_act   = lowest(cand);
                end
            end else if (m_offer) begin
                if (!cand[m_act]) begin
                    m_offer = 0;
                end else if (clr) begin
                    m_offer = 0;
                    m_svc   = 1;
                    acc_id  = m_act;
                end
            end else if (eoi_wr) begin
                m_svc = 0;
            end
            np = m_pend & ~w1c;
            if (acc_id >= 0) np[acc_id] = 1'b0;
            np = np | (src & ~m_prev);
            for (int i = 0; i < NSRC; i++) begin
                if (TB_LVL[i]) np[i] = src[i];
            end
            m_pend = np;
            if (addr == 2'd1) m_en = (m_en & ~wm[NSRC-1:0]) | w32[NSRC-1:0];
            m_prev = src;
        end
        @(posedge clk);
        #1;
        cand = m_pend & m_en;
        chk("cyc_int_pending", 32'(ipend), 32'(m_offer && cand[m_act]));
        chk("cyc_int_type", 32'(itype), 32'(m_act));
        chk("cyc_data_out", dout, m_dout);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        din  = d;
        wren = 4'hF;
        step();
        wren = 4'h0;
    endtask

    task automatic rd(input logic [1:0] a);
        addr = a;
        re   = 1'b1;
        step();
        re   = 1'b0;
    endtask

    task automatic accept_and_eoi();
        clr = 1'b1;
        step();
        clr = 1'b0;
        wr(2'd2, 32'h1);
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        failed_checks = 0;
        srst = 1'b1;
        src  = 8'h80;
        addr = 2'd0;
        wren = 4'h0;
        re   = 1'b0;
        din  = '0;
        clr  = 1'b0;

        // Reset with a line held high across it
        repeat (3) step();
        chk("rst_int_pending", 32'(ipend), 32'd0);
        chk("rst_int_type", 32'(itype), 32'd0);
        chk("rst_data_out", dout, 32'd0);
        srst = 1'b0;
        step();
        rd(2'd0);
        chk("rst_no_edge_pending", dout, 32'd0);
        src = 8'h00;
        rd(2'd1);
        chk("rst_enable", dout, 32'd0);

        // 1: single source, offer latency, accept, STATUS
        wr(2'd1, 32'h05);
        src = 8'h04;
        step();
        src = 8'h00;
        chk("t1_not_yet", 32'(ipend), 32'd0);
        step();
        chk("t1_offer", 32'(ipend), 32'd1);
        chk("t1_type", 32'(itype), 32'd2);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t1_accept_drop", 32'(ipend), 32'd0);
        rd(2'd0);
        chk("t1_pending_rd", dout, 32'h00);
        rd(2'd2);
        chk("t1_status_rd", dout, 32'h80000002);
        wr(2'd2, 32'h0);

        // 2: simultaneous sources, priority, EOI re-offer
        wr(2'd1, 32'hFF);
        src = 8'h05;
        step();
        step();
        chk("t2_offer", 32'(ipend), 32'd1);
        chk("t2_type0", 32'(itype), 32'd0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        src = 8'h00;
        step();
        wr(2'd2, 32'h0);
        chk("t2_after_eoi", 32'(ipend), 32'd0);
        step();
        chk("t2_reoffer", 32'(ipend), 32'd1);
        chk("t2_type2", 32'(itype), 32'd2);
        accept_and_eoi();

        // 3: frozen id, W1C withdraws, re-arbitration
        src = 8'h08;
        step();
        src = 8'h00;
        step();
        chk("t3_type3", 32'(itype), 32'd3);
        src = 8'h02;
        step();
        src = 8'h00;
        step();
        chk("t3_frozen_pend", 32'(ipend), 32'd1);
        chk("t3_frozen_type", 32'(itype), 32'd3);
        wr(2'd0, 32'h08);
        chk("t3_withdrawn", 32'(ipend), 32'd0);
        step();
        step();
        chk("t3_reoffer", 32'(ipend), 32'd1);
        chk("t3_type1", 32'(itype), 32'd1);
        accept_and_eoi();

        // 4: arrivals during service wait for EOI
        src = 8'h40;
        step();
        src = 8'h00;
        step();
        chk("t4_type6", 32'(itype), 32'd6);
        clr = 1'b1;
        step();
        clr = 1'b0;
        src = 8'h10;
        step();
        src = 8'h00;
        repeat (3) step();
        chk("t4_held_in_svc", 32'(ipend), 32'd0);
        wr(2'd2, 32'h0);
        step();
        chk("t4_offer", 32'(ipend), 32'd1);
        chk("t4_type4", 32'(itype), 32'd4);
        accept_and_eoi();

        // 5: edge beats a same-cycle W1C
        wr(2'd1, 32'h00);
        src = 8'h20;
        wr(2'd0, 32'h20);
        src = 8'h00;
        rd(2'd0);
        chk("t5_set_wins", dout, 32'h20);
        wr(2'd0, 32'h20);
        rd(2'd0);
        chk("t5_w1c", dout, 32'h00);

`ifdef MCPU_INTC_LEVEL_EN
        // Level source 0 re-offers after EOI while held high
        wr(2'd1, 32'h01);
        src = 8'h01;
        step();
        step();
        chk("lvl_offer", 32'(ipend), 32'd1);
        chk("lvl_type0", 32'(itype), 32'd0);
        accept_and_eoi();
        step();
        chk("lvl_reoffer", 32'(ipend), 32'd1);
        chk("lvl_retype", 32'(itype), 32'd0);
        src = 8'h00;
        step();
        chk("lvl_drop", 32'(ipend), 32'd0);
        rd(2'd0);
        chk("lvl_pending0", dout, 32'h00);
        step();
        chk("lvl_no_offer", 32'(ipend), 32'd0);
`endif

        // Random traffic against the model
        wr(2'd1, 32'hFF);
        for (int c = 0; c < 1500; c++) begin
            int r;
            if ($urandom_range(0, 3) == 0) src = src ^ (8'd1 << $urandom_range(0, 7));
            clr  = ($urandom_range(0, 4) == 0);
            r    = int'($urandom_range(0, 9));
            addr = 2'($urandom_range(0, 3));
            din  = $urandom;
            wren = (r < 2) ? 4'($urandom_range(0, 15)) : 4'h0;
            re   = (r >= 2 && r < 5);
            step();
        end
        clr  = 1'b0;
        wren = 4'h0;
        re   = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
